// File: rtl/xcorr_pkg.sv
// Shared sizing, value types and FSM state encoding for the cross-correlation peak finder.
package xcorr_pkg;

  localparam int NUM_BITS_XCORR    = 32;
  localparam int MAX_SAMPLES_DELAY = 11;
  localparam int NUM_XCORRS        = 6;
  localparam int NUM_LAGS          = 2 * MAX_SAMPLES_DELAY + 1;
  localparam int LAG_BITS          = $clog2(MAX_SAMPLES_DELAY + 1) + 1;

  typedef logic signed [NUM_BITS_XCORR-1:0]                xcorr_t;
  typedef logic signed [NUM_LAGS-1:0][NUM_BITS_XCORR-1:0]  xcorr_vec_t;
  typedef logic signed [LAG_BITS-1:0]                      lag_t;

  typedef enum logic [1:0] {
    PEAK_IDLE,
    PEAK_SCAN,
    PEAK_DONE
  } peak_state_e;

endpackage

// File: rtl/xcorr_argmax_lane.sv
// One comparator lane: snapshots a correlation vector and tracks its running maximum and index.
module xcorr_argmax_lane
  import xcorr_pkg::*;
#(
  parameter int W        = 32,
  parameter int NUM_LAGS = 23,
  parameter int IDX_BITS = 5
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             load,
  input  logic                             step,
  input  logic [IDX_BITS-1:0]              index,
  input  logic [NUM_LAGS-1:0][W-1:0]       vector,
  output logic signed [W-1:0]              best,
  output logic [IDX_BITS-1:0]              best_idx
);

  logic signed [W-1:0]   snap [NUM_LAGS];
  logic signed [W-1:0]   best_r;
  logic [IDX_BITS-1:0]   idx_r;

  // Outputs already include this cycle's compare, so the final step's result can be latched directly.
  always_comb begin
    best     = best_r;
    best_idx = idx_r;
    if (step && (snap[index] > best_r)) begin
      best     = snap[index];
      best_idx = index;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < NUM_LAGS; k++) snap[k] <= '0;
      best_r <= '0;
      idx_r  <= '0;
    end else if (load) begin
      for (int unsigned k = 0; k < NUM_LAGS; k++) snap[k] <= vector[k];
      best_r <= vector[0];
      idx_r  <= '0;
    end else if (step) begin
      best_r <= best;
      idx_r  <= best_idx;
    end
  end

endmodule

// File: rtl/xcorr_peak_finder.sv
// Serial argmax over six correlation vectors; reports signed lag and peak behind a valid/ready handshake.
module xcorr_peak_finder
  import xcorr_pkg::*;
#(
  parameter int NUM_BITS_XCORR    = 32,
  parameter int MAX_SAMPLES_DELAY = 11,
  parameter int NUM_XCORRS        = 6,
  parameter int LAG_BITS          = $clog2(MAX_SAMPLES_DELAY + 1) + 1
) (
  input  logic                                                     clk,
  input  logic                                                     rst,
  input  logic                                                     validIn,
  input  logic signed [2*MAX_SAMPLES_DELAY:0][NUM_BITS_XCORR-1:0]  xCorrIn0,
  input  logic signed [2*MAX_SAMPLES_DELAY:0][NUM_BITS_XCORR-1:0]  xCorrIn1,
  input  logic signed [2*MAX_SAMPLES_DELAY:0][NUM_BITS_XCORR-1:0]  xCorrIn2,
  input  logic signed [2*MAX_SAMPLES_DELAY:0][NUM_BITS_XCORR-1:0]  xCorrIn3,
  input  logic signed [2*MAX_SAMPLES_DELAY:0][NUM_BITS_XCORR-1:0]  xCorrIn4,
  input  logic signed [2*MAX_SAMPLES_DELAY:0][NUM_BITS_XCORR-1:0]  xCorrIn5,
  input  logic                                                     readyIn,
  output logic                                                     validOut,
  output logic signed [LAG_BITS-1:0]                               lagOut0,
  output logic signed [LAG_BITS-1:0]                               lagOut1,
  output logic signed [LAG_BITS-1:0]                               lagOut2,
  output logic signed [LAG_BITS-1:0]                               lagOut3,
  output logic signed [LAG_BITS-1:0]                               lagOut4,
  output logic signed [LAG_BITS-1:0]                               lagOut5,
  output logic signed [NUM_BITS_XCORR-1:0]                         peakOut0,
  output logic signed [NUM_BITS_XCORR-1:0]                         peakOut1,
  output logic signed [NUM_BITS_XCORR-1:0]                         peakOut2,
  output logic signed [NUM_BITS_XCORR-1:0]                         peakOut3,
  output logic signed [NUM_BITS_XCORR-1:0]                         peakOut4,
  output logic signed [NUM_BITS_XCORR-1:0]                         peakOut5,
  output logic                                                     busy,
  output logic                                                     overrun
);

  localparam int N_LAGS   = 2 * MAX_SAMPLES_DELAY + 1;
  localparam int IDX_BITS = $clog2(N_LAGS);
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(N_LAGS - 1);

  peak_state_e state, state_next;
  logic [IDX_BITS-1:0] idx;
  logic load, step, finish, drop;

  logic [N_LAGS-1:0][NUM_BITS_XCORR-1:0] vec_in    [NUM_XCORRS];
  logic signed [NUM_BITS_XCORR-1:0]      lane_best [NUM_XCORRS];
  logic [IDX_BITS-1:0]                   lane_idx  [NUM_XCORRS];
  logic signed [LAG_BITS-1:0]            lag_r     [NUM_XCORRS];
  logic signed [NUM_BITS_XCORR-1:0]      peak_r    [NUM_XCORRS];

  assign vec_in[0] = xCorrIn0;
  assign vec_in[1] = xCorrIn1;
  assign vec_in[2] = xCorrIn2;
  assign vec_in[3] = xCorrIn3;
  assign vec_in[4] = xCorrIn4;
  assign vec_in[5] = xCorrIn5;

  // Subtract in one extra bit so the index is never misread as negative, then narrow.
  function automatic logic signed [LAG_BITS-1:0] lag_of(input logic [IDX_BITS-1:0] i);
    logic signed [LAG_BITS:0] wide;
    wide = $signed((LAG_BITS+1)'(i)) - $signed((LAG_BITS+1)'(MAX_SAMPLES_DELAY));
    return LAG_BITS'(wide);
  endfunction

  for (genvar g = 0; g < NUM_XCORRS; g++) begin : g_lane
    xcorr_argmax_lane #(
      .W        (NUM_BITS_XCORR),
      .NUM_LAGS (N_LAGS),
      .IDX_BITS (IDX_BITS)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .step     (step),
      .index    (idx),
      .vector   (vec_in[g]),
      .best     (lane_best[g]),
      .best_idx (lane_idx[g])
    );
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    drop       = validIn && (state != PEAK_IDLE);
    case (state)
      PEAK_IDLE: begin
        if (validIn) begin
          load       = 1'b1;
          state_next = PEAK_SCAN;
        end
      end
      PEAK_SCAN: begin
        step = 1'b1;
        if (idx == LAST_IDX) begin
          finish     = 1'b1;
          state_next = PEAK_DONE;
        end
      end
      PEAK_DONE: begin
        if (readyIn) state_next = PEAK_IDLE;
      end
      default: state_next = PEAK_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= PEAK_IDLE;
      idx     <= '0;
      overrun <= 1'b0;
      for (int unsigned g = 0; g < NUM_XCORRS; g++) begin
        lag_r[g]  <= '0;
        peak_r[g] <= '0;
      end
    end else begin
      state <= state_next;
      if (load)      idx <= IDX_BITS'(1);
      else if (step) idx <= idx + IDX_BITS'(1);
      if (drop) overrun <= 1'b1;
      if (finish) begin
        for (int unsigned g = 0; g < NUM_XCORRS; g++) begin
          lag_r[g]  <= lag_of(lane_idx[g]);
          peak_r[g] <= lane_best[g];
        end
      end
    end
  end

  assign validOut = (state == PEAK_DONE);
  assign busy     = (state != PEAK_IDLE);

  assign lagOut0  = lag_r[0];
  assign lagOut1  = lag_r[1];
  assign lagOut2  = lag_r[2];
  assign lagOut3  = lag_r[3];
  assign lagOut4  = lag_r[4];
  assign lagOut5  = lag_r[5];
  assign peakOut0 = peak_r[0];
  assign peakOut1 = peak_r[1];
  assign peakOut2 = peak_r[2];
  assign peakOut3 = peak_r[3];
  assign peakOut4 = peak_r[4];
  assign peakOut5 = peak_r[5];

endmodule
